// File: rtl/mfp_uart_tx_pkg.sv
// Shared UART constants: FSM state encodings, baud divisor helper, default line rate (also used by the receiver).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mfp_uart_tx_pkg;

    localparam int UART_DEFAULT_BAUD = 115_200;

`ifdef MFP_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } uart_state_t;
`endif

    // Clock cycles per bit, rounded to nearest.
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/mfp_uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; full/empty derived from the count.
// Latency: pushed word visible at pop_dat the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; simultaneous push/pop allowed.
module mfp_uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mfp_uart_tx.sv
// UART transmitter: FIFO-buffered bytes sent as 8N1 frames, LSB first (8E1 when MFP_UART_TX_PARITY_EN is defined).
// Latency: byte accepted at edge k into an idle block drives the start bit from edge k+2.
// Backpressure: tx_ready = !full from the registered count; producer holds tx_data until accepted.
module mfp_uart_tx
    import mfp_uart_tx_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = UART_DEFAULT_BAUD,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          UART_TX
);
    localparam int             DIV      = uart_div(CLK_HZ, BAUD);
    localparam int             CW       = $clog2(DIV);
    localparam logic [CW-1:0]  BIT_LAST = CW'(DIV - 1);

    uart_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          line_q, line_d;
    logic          bit_done;
    logic          fifo_pop;
    logic [7:0]    fifo_dat;
    logic          fifo_full;
    logic          fifo_empty;
`ifdef MFP_UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    mfp_uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (HCLK),
        .rst_n    (HRESETn),
        .push     (tx_valid && tx_ready),
        .push_dat (tx_data),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign tx_ready = !fifo_full;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;
    assign UART_TX  = line_q;
    assign bit_done = (cnt_q == '0);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            line_q  <= 1'b1;
`ifdef MFP_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            line_q  <= line_d;
`ifdef MFP_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        line_d   = 1'b1;
        fifo_pop = 1'b0;
`ifdef MFP_UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        if (state_q != ST_IDLE && !bit_done) begin
            cnt_d = cnt_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dat;
                    cnt_d    = BIT_LAST;
                    state_d  = ST_START;
`ifdef MFP_UART_TX_PARITY_EN
                    par_d    = ^fifo_dat;
`endif
                end
            end
            ST_START: begin
                line_d = 1'b0;
                if (bit_done) begin
                    cnt_d   = BIT_LAST;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                line_d = shift_q[0];
                if (bit_done) begin
                    cnt_d   = BIT_LAST;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 3'd7) begin
`ifdef MFP_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef MFP_UART_TX_PARITY_EN
            ST_PARITY: begin
                line_d = par_q;
                if (bit_done) begin
                    cnt_d   = BIT_LAST;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                line_d = 1'b1;
                if (bit_done) begin
                    // Back-to-back frames: next start bit follows the stop bit directly.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dat;
                        cnt_d    = BIT_LAST;
                        state_d  = ST_START;
`ifdef MFP_UART_TX_PARITY_EN
                        par_d    = ^fifo_dat;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
